// File: rtl/vdp_vram_arb.sv
// vdp_vram_arb: owns the single VRAM port, arbitrating between display DMA reads and the
// CPU data port. Holds the CPU address register, one-entry op slot and the read-ahead latch.
module vdp_vram_arb #(
  parameter int unsigned VRAM_SIZE    = 8192,
  parameter int unsigned STARVE_LIMIT = 32,
  localparam int unsigned AW          = $clog2(VRAM_SIZE)
) (
  input  logic          pxclk,
  input  logic          reset,
  input  logic          wr_tick,
  input  logic          rd_tick,
  input  logic          mode,
  input  logic [7:0]    din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_busy,
  output logic          overrun,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_grant,
  output logic          dma_valid,
  output logic [7:0]    dma_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PEND_WR, PEND_RD, RD_WAIT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    low_q, low_d;
  logic          toggle_q, toggle_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          dma_valid_q;
  logic [7:0]    dma_hold_q, dma_hold_d;

  logic          data_wr_c, data_rd_c, ctl_wr_c, ctl_rd_c;
  logic          rd_setup_c, new_op_c, pending_c, issue_c, grant_c;
  logic          slot_free_c, accept_c, drop_c;
  logic [AW-1:0] mem_addr_c, addr_inc_c;
  logic          mem_re_c, mem_we_c;
  logic [7:0]    mem_wdata_c;

  // Tick decode and slot arbitration; the slot also frees on the cycle its op issues.
  always_comb begin
    data_wr_c   = wr_tick & ~mode;
    data_rd_c   = rd_tick & ~mode;
    ctl_wr_c    = wr_tick & mode;
    ctl_rd_c    = rd_tick & mode;
    rd_setup_c  = ctl_wr_c & toggle_q & ~din[7] & ~din[6];
    new_op_c    = data_wr_c | data_rd_c | rd_setup_c;
    pending_c   = (state_q == PEND_WR) || (state_q == PEND_RD);
    issue_c     = pending_c && (!dma_req || (starve_q == SW'(STARVE_LIMIT)));
    grant_c     = dma_req && !issue_c;
    slot_free_c = (state_q == IDLE) || issue_c;
    accept_c    = new_op_c & slot_free_c;
    drop_c      = new_op_c & ~slot_free_c;
    addr_inc_c  = (addr_q == AW'(VRAM_SIZE - 1)) ? '0 : addr_q + AW'(1);
  end

  // Next-state, address register and VRAM port drive.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    low_d         = low_q;
    toggle_d      = toggle_q;
    wdata_d       = wdata_q;
    starve_d      = '0;
    rd_inflight_d = 1'b0;
    cpu_dout_d    = cpu_dout_q;
    overrun_d     = overrun_q;
    dma_hold_d    = dma_valid_q ? mem_rdata : dma_hold_q;
    mem_addr_c    = '0;
    mem_re_c      = 1'b0;
    mem_we_c      = 1'b0;
    mem_wdata_c   = '0;

    if (state_q == RD_WAIT) begin
      state_d = IDLE;
    end
    if (rd_inflight_q) begin
      cpu_dout_d = mem_rdata;
    end

    if (issue_c) begin
      mem_addr_c = addr_q;
      addr_d     = addr_inc_c;
      if (state_q == PEND_WR) begin
        mem_we_c    = 1'b1;
        mem_wdata_c = wdata_q;
        cpu_dout_d  = wdata_q;
        state_d     = IDLE;
      end else begin
        mem_re_c      = 1'b1;
        rd_inflight_d = 1'b1;
        state_d       = RD_WAIT;
      end
    end else begin
      if (pending_c) begin
        starve_d = starve_q + SW'(1);
      end
      if (grant_c) begin
        mem_re_c   = 1'b1;
        mem_addr_c = dma_addr;
      end
    end

    if (ctl_rd_c) begin
      toggle_d  = 1'b0;
      overrun_d = 1'b0;
    end
    // Two-byte control write: low address byte first, then high byte / register write.
    if (ctl_wr_c) begin
      if (!toggle_q) begin
        low_d    = din;
        toggle_d = 1'b1;
      end else begin
        toggle_d = 1'b0;
        if (!din[7]) begin
          addr_d = AW'({din[5:0], low_q});
        end
      end
    end

    if (accept_c) begin
      if (data_wr_c) begin
        state_d = PEND_WR;
        wdata_d = din;
      end else begin
        state_d = PEND_RD;
      end
    end
    if (drop_c) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      low_q         <= '0;
      toggle_q      <= 1'b0;
      wdata_q       <= '0;
      starve_q      <= '0;
      rd_inflight_q <= 1'b0;
      cpu_dout_q    <= '0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      dma_valid_q   <= 1'b0;
      dma_hold_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      low_q         <= low_d;
      toggle_q      <= toggle_d;
      wdata_q       <= wdata_d;
      starve_q      <= starve_d;
      rd_inflight_q <= rd_inflight_d;
      cpu_dout_q    <= cpu_dout_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      dma_valid_q   <= grant_c;
      dma_hold_q    <= dma_hold_d;
    end
  end

  // Port strobes are same-cycle; force them quiet while reset is asserted.
  assign mem_addr  = reset ? '0 : mem_addr_c;
  assign mem_re    = mem_re_c & ~reset;
  assign mem_we    = mem_we_c & ~reset;
  assign mem_wdata = reset ? '0 : mem_wdata_c;
  assign dma_grant = grant_c & ~reset;
  assign dma_valid = dma_valid_q;
  assign dma_data  = dma_valid_q ? mem_rdata : dma_hold_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_busy  = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/vdp_vram_arb.md
Name: vdp_vram_arb

Overview:
- Owns the single VRAM port in vdp99 and shares it between two requesters: the display FSM DMA reads and the CPU data port (mode 0).
- Holds the CPU VRAM address register and decodes the two-byte mode 1 address setup.
- Buffers CPU read/write ticks until a free VRAM slot, auto-increments the address and keeps a read-ahead latch, so CPU reads never return stale DMA data.
- Sits between vdp_reg_ifce/CPU tick logic, vdp_fsm and vram.

Parameters:
- VRAM_SIZE, 8192, VRAM bytes; address width AW = $clog2(VRAM_SIZE).
- STARVE_LIMIT, 32, max cycles a pending CPU op may wait before it preempts DMA.

Ports:
- pxclk  in  1  pixel clock, 25 MHz; sole clock.
- reset  in  1  asynchronous, active-high reset.
- wr_tick  in  1  CPU write strobe, pxclk domain, one cycle.
- rd_tick  in  1  CPU read strobe, pxclk domain, one cycle.
- mode  in  1  port select, valid with ticks (0 = VRAM data, 1 = control).
- din  in  8  CPU write data.
- cpu_dout  out  8  read-ahead latch, presented to CPU on mode 0 read.
- cpu_busy  out  1  a CPU op is pending or in flight.
- overrun  out  1  sticky; a CPU op was dropped; cleared by reset or a mode 1 read.
- dma_req  in  1  FSM requests a VRAM read this cycle.
- dma_addr  in  AW  FSM read address.
- dma_grant  out  1  dma_req accepted this cycle.
- dma_valid  out  1  dma_data valid; exactly 1 cycle after a granted dma_req.
- dma_data  out  8  DMA read data.
- mem_addr  out  AW  VRAM address.
- mem_re  out  1  VRAM read enable.
- mem_we  out  1  VRAM write enable.
- mem_wdata  out  8  VRAM write data.
- mem_rdata  in  8  VRAM read data, 1-cycle synchronous latency.

Behaviour:
- Reset values: all outputs 0; addr = 0; byte toggle = first; state = IDLE; starve_cnt = 0.
- Address setup (wr_tick with mode=1):
  - First byte: latch it as the low address byte; toggle -> second.
  - Second byte, bit7=0: addr = {din[5:0], low}, truncated to AW bits.
    - din[6]=0: read setup; queue a prefetch read (PEND_RD, no data return to CPU).
    - din[6]=1: write setup; no memory access.
  - Second byte, bit7=1: register write, handled by vdp_reg_ifce; addr unchanged.
  - Toggle returns to first after any second byte.
- Any rd_tick with mode=1 resets the toggle to first and clears overrun.
- Mode 0 write: queue PEND_WR with data = din.
- Mode 0 read: cpu_dout is already on the bus and sampled by the CPU during the tick; queue PEND_RD.
- Pending slot holds one entry. A mode 0 tick or read setup while cpu_busy=1 is dropped and sets overrun; addr is not advanced.
- Grant per cycle:
  - If a CPU op is pending and starve_cnt < STARVE_LIMIT: dma_req wins (dma_grant=1, mem_re=1, mem_addr=dma_addr).
  - Otherwise the CPU op issues (dma_grant=0); the FSM must tolerate a missing grant.
  - A CPU op issues on the first cycle with dma_req=0, or on the cycle when starve_cnt = STARVE_LIMIT.
- starve_cnt increments each cycle a CPU op waits and resets to 0 on issue.
- CPU write issue: mem_we=1, mem_addr=addr, mem_wdata=data. cpu_dout is loaded with data. addr = addr+1 mod VRAM_SIZE. Return to IDLE the same cycle; cpu_busy drops the next cycle.
- CPU read issue: mem_re=1, mem_addr=addr, addr = addr+1, go to RD_WAIT. In RD_WAIT, cpu_dout = mem_rdata, return to IDLE. DMA may be granted during RD_WAIT.
- States: IDLE, PEND_WR, PEND_RD, RD_WAIT. Worst-case tick-to-idle is STARVE_LIMIT+2 cycles.
- dma_valid = registered dma_grant, and dma_data = mem_rdata in that cycle; dma_data holds otherwise.
- Address wraps from VRAM_SIZE-1 to 0.
- A tick arriving in the same cycle a pending op issues is accepted; the slot frees that cycle.
- Reset mid-operation aborts any pending/in-flight op. No write occurs after reset asserts.

Test Plan:
- Control writes 0x34, 0x52 then mode 0 write 0xA5 -> one mem_we at addr 0x1234, mem_wdata 0xA5; addr becomes 0x1235; cpu_dout 0xA5.
- Preload VRAM[0x0100]=0x11 and [0x0101]=0x22; control writes 0x00, 0x01 (read setup) -> prefetch makes cpu_dout 0x11; mode 0 read returns 0x11, then cpu_dout becomes 0x22.
- dma_req held high for 100 cycles with a pending CPU write -> write issues exactly at wait cycle 32, with dma_grant=0 on that cycle only.
- dma_req toggling 1/0 with a CPU read pending -> read issues on the first 0 cycle; dma_valid trails every dma_grant by 1 cycle with correct data.
- Second mode 0 write while cpu_busy -> dropped, overrun=1, only the first write lands; a mode 1 read then clears overrun.
- Setup write at 0x1FFF (VRAM_SIZE=8192), two writes -> land at 0x1FFF then 0x0000; reset asserted between tick and issue -> no mem_we, all outputs 0.
